// File: rtl/reset_sequencer.sv
// reset_sequencer
// Generates NUM_DOMAINS staggered, maskable, re-triggerable active-high reset
// pulses plus a free-running heartbeat. A sequence runs automatically after
// rst_n is released; later sequences are requested with start.
//
// Ports:
//   clk             clock
//   rst_n           asynchronous active-low reset
//   start           request a new sequence (sampled every rising edge)
//   domain_mask     domains to pulse, captured when a sequence starts
//   dom_reset       per-domain active-high resets (one flop per bit)
//   busy            sequence in progress
//   done            one-cycle pulse at the end of a sequence
//   start_dropped   sticky: a start arrived while a sequence was running
//   heartbeat       one-cycle pulse every HB_PERIOD cycles
//   heartbeat_count saturating count of heartbeat pulses
module reset_sequencer #(
    parameter int NUM_DOMAINS    = 4,
    parameter int PRE_CYCLES     = 3,
    parameter int ASSERT_CYCLES  = 3,
    parameter int STAGGER_CYCLES = 2,
    parameter int HB_PERIOD      = 1000,
    parameter int HB_WIDTH       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_DOMAINS-1:0] domain_mask,
    output logic [NUM_DOMAINS-1:0] dom_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   start_dropped,
    output logic                   heartbeat,
    output logic [HB_WIDTH-1:0]    heartbeat_count
);

    localparam int LAST_FALL = ASSERT_CYCLES + (NUM_DOMAINS - 1) * STAGGER_CYCLES;
    localparam int PHASE_MAX = (PRE_CYCLES > LAST_FALL) ? PRE_CYCLES : LAST_FALL;
    localparam int CW        = $clog2(PHASE_MAX + 1);
    localparam int HW        = $clog2(HB_PERIOD);

    localparam logic [CW-1:0] PRE_LAST = CW'(PRE_CYCLES - 1);
    localparam logic [HW-1:0] HB_LAST  = HW'(HB_PERIOD - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_ASSERT  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                 state_r, state_s;
    logic [CW-1:0]          cnt_r, cnt_s;
    logic [NUM_DOMAINS-1:0] mask_r, mask_s;
    logic [NUM_DOMAINS-1:0] dom_r, dom_s;
    logic [NUM_DOMAINS-1:0] fall_s;
    logic                   auto_r, auto_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;
    logic                   drop_r, drop_s;
    logic [HW-1:0]          hb_cnt_r;
    logic                   hb_r;
    logic [HB_WIDTH-1:0]    hbc_r;

    // Per-domain release strobe: domain i falls when the post-rise count reaches its stagger slot.
    always_comb begin
        fall_s = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            fall_s[i] = (cnt_r == CW'(ASSERT_CYCLES + i * STAGGER_CYCLES - 1));
        end
    end

    // Next-state and next-output logic of the sequencing FSM.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        mask_s  = mask_r;
        auto_s  = auto_r;
        dom_s   = dom_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        drop_s  = drop_r;

        case (state_r)
            ST_IDLE: begin
                if (auto_r || start) begin
                    mask_s  = domain_mask;
                    auto_s  = 1'b0;
                    cnt_s   = '0;
                    busy_s  = 1'b1;
                    state_s = ST_PRE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (mask_r == '0) begin
                    // Nothing to pulse: finish after a single busy cycle.
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = ST_DONE;
                end else if (cnt_r == PRE_LAST) begin
                    dom_s   = mask_r;
                    cnt_s   = '0;
                    state_s = ST_ASSERT;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_ASSERT, ST_RELEASE: begin
                cnt_s = cnt_r + CW'(1);
                dom_s = dom_r & ~fall_s;
                // All masked bits are high until they fall, so the vector empties
                // exactly when the highest masked domain is released.
                if (dom_s == '0) begin
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = ST_DONE;
                end else if (fall_s[0]) begin
                    state_s = ST_RELEASE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                dom_s   = '0;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase

        // Any start outside IDLE (including the DONE cycle) is dropped and remembered.
        if (start && (state_r != ST_IDLE)) begin
            drop_s = 1'b1;
        end else begin
            drop_s = drop_r;
        end
    end

    // FSM state, phase counter and registered sequence outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            mask_r  <= '0;
            auto_r  <= 1'b1;
            dom_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            mask_r  <= mask_s;
            auto_r  <= auto_s;
            dom_r   <= dom_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            drop_r  <= drop_s;
        end
    end

    // Free-running heartbeat divider with a saturating pulse counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_r <= '0;
            hb_r     <= 1'b0;
            hbc_r    <= '0;
        end else if (hb_cnt_r == HB_LAST) begin
            hb_cnt_r <= '0;
            hb_r     <= 1'b1;
            if (hbc_r != {HB_WIDTH{1'b1}}) begin
                hbc_r <= hbc_r + HB_WIDTH'(1);
            end else begin
                hbc_r <= hbc_r;
            end
        end else begin
            hb_cnt_r <= hb_cnt_r + HW'(1);
            hb_r     <= 1'b0;
            hbc_r    <= hbc_r;
        end
    end

    assign dom_reset       = dom_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign start_dropped   = drop_r;
    assign heartbeat       = hb_r;
    assign heartbeat_count = hbc_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: per-edge expected values are built from the
// sequence timing formulas into a vector table, pushed to a scoreboard queue as
// each edge is driven, and popped/compared one time unit after that edge.
module tb_reset_sequencer;

    localparam int PRE  = 3;
    localparam int ASRT = 3;
    localparam int STAG = 2;
    localparam int HBP  = 4;
    localparam int MAXE = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] domain_mask;
    logic [3:0] dom_reset;
    logic       busy, done, start_dropped, heartbeat;
    logic [1:0] heartbeat_count;

    reset_sequencer #(
        .NUM_DOMAINS(4), .PRE_CYCLES(PRE), .ASSERT_CYCLES(ASRT),
        .STAGGER_CYCLES(STAG), .HB_PERIOD(HBP), .HB_WIDTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .domain_mask(domain_mask),
        .dom_reset(dom_reset), .busy(busy), .done(done),
        .start_dropped(start_dropped), .heartbeat(heartbeat),
        .heartbeat_count(heartbeat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [3:0] mask;
        logic [3:0] dom;
        logic       busy;
        logic       done;
        logic       drop;
    } vec_t;

    typedef struct {
        int         edge_n;
        logic [3:0] dom;
        logic       busy;
        logic       done;
        logic       drop;
        logic       hb;
        logic [1:0] hbc;
    } exp_t;

    vec_t vecs [1:MAXE];
    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int e, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge %0d: got %0h expected %0h", name, e, act, exp);
        end
    endtask

    task automatic clear_vecs();
        for (int e = 1; e <= MAXE; e++) begin
            vecs[e] = '{1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0};
        end
    endtask

    // Expected waveform of one sequence started at edge s with mask m.
    task automatic add_seq(input int s, input logic [3:0] m);
        int r;
        int f;
        int fi;
        vecs[s].mask = m;
        if (m == 4'h0) begin
            vecs[s].busy     = 1'b1;
            vecs[s + 1].done = 1'b1;
        end else begin
            r = s + PRE;
            f = 0;
            for (int i = 0; i < 4; i++) begin
                if (m[i]) begin
                    fi = r + ASRT + i * STAG;
                    for (int e = r; e < fi; e++) vecs[e].dom[i] = 1'b1;
                    if (fi > f) f = fi;
                end
            end
            for (int e = s; e < f; e++) vecs[e].busy = 1'b1;
            vecs[f].done = 1'b1;
        end
    endtask

    // Apply table rows lo..hi; row e is the stimulus for, and response after, edge e.
    task automatic run_range(input int lo, input int hi);
        exp_t x;
        exp_t got;
        for (int e = lo; e <= hi; e++) begin
            start       = vecs[e].start;
            domain_mask = vecs[e].mask;
            x.edge_n = e;
            x.dom    = vecs[e].dom;
            x.busy   = vecs[e].busy;
            x.done   = vecs[e].done;
            x.drop   = vecs[e].drop;
            x.hb     = ((e % HBP) == 0);
            x.hbc    = ((e / HBP) > 3) ? 2'd3 : 2'(e / HBP);
            exp_q.push_back(x);
            @(posedge clk);
            #1;
            got = exp_q.pop_front();
            chk("dom_reset",       got.edge_n, 32'(dom_reset),       32'(got.dom));
            chk("busy",            got.edge_n, 32'(busy),            32'(got.busy));
            chk("done",            got.edge_n, 32'(done),            32'(got.done));
            chk("start_dropped",   got.edge_n, 32'(start_dropped),   32'(got.drop));
            chk("heartbeat",       got.edge_n, 32'(heartbeat),       32'(got.hb));
            chk("heartbeat_count", got.edge_n, 32'(heartbeat_count), 32'(got.hbc));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dom_reset"}, 0, 32'(dom_reset), 32'h0);
        chk({tag, "_busy"},      0, 32'(busy), 32'h0);
        chk({tag, "_done"},      0, 32'(done), 32'h0);
        chk({tag, "_drop"},      0, 32'(start_dropped), 32'h0);
        chk({tag, "_hb"},        0, 32'(heartbeat), 32'h0);
        chk({tag, "_hbc"},       0, 32'(heartbeat_count), 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b1;
        start       = 1'b0;
        domain_mask = 4'hF;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        do_reset();

        // Auto sequence, masked sequence at 20, held start at 33..47, zero mask at 58.
        clear_vecs();
        add_seq(1, 4'hF);
        add_seq(20, 4'b0101);
        vecs[20].start = 1'b1;
        add_seq(33, 4'hF);
        vecs[33].start = 1'b1;
        for (int e = 34; e <= 46; e++) begin
            vecs[e].start = 1'b1;
            vecs[e].mask  = 4'(e * 5);
        end
        add_seq(47, 4'b0010);
        vecs[47].start = 1'b1;
        add_seq(58, 4'h0);
        vecs[58].start = 1'b1;
        for (int e = 34; e <= 62; e++) vecs[e].drop = 1'b1;
        run_range(1, 62);

        // Async reset mid-RELEASE, then the auto sequence must rerun from edge 1.
        start = 1'b0;
        do_reset();
        clear_vecs();
        add_seq(1, 4'hF);
        run_range(1, 8);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        do_reset();
        run_range(1, 14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised reset-pulse generator for multi-domain CGRA benches and SoC glue. Generalises the single up-and-down bench reset into NUM_DOMAINS staggered, maskable, re-triggerable reset outputs.
- Adds a free-running heartbeat counter, which lets benches and monitors timestamp progress without `$display` polling.
- Sits between the top-level clock/reset source and the Garnet/global-buffer reset inputs.

Parameters:
- NUM_DOMAINS, 4: number of independent reset outputs (1..16).
- PRE_CYCLES, 3: cycles low before assertion (>=1).
- ASSERT_CYCLES, 3: cycles all masked domains held high (>=1).
- STAGGER_CYCLES, 2: extra cycles between successive domain releases (>=0).
- HB_PERIOD, 1000: heartbeat period in cycles (>=2).
- HB_WIDTH, 32: heartbeat_count width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new sequence; sampled each rising edge.
- domain_mask  in  NUM_DOMAINS  domains to pulse; captured when a sequence starts.
- dom_reset  out  NUM_DOMAINS  active-high domain resets.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- start_dropped  out  1  sticky flag: start was seen while busy.
- heartbeat  out  1  one-cycle pulse every HB_PERIOD cycles.
- heartbeat_count  out  HB_WIDTH  number of heartbeat pulses, saturating.

Behaviour:
- Reset asserted (rst_n low, async):
  - dom_reset=0, busy=0, done=0, start_dropped=0, heartbeat=0, heartbeat_count=0, FSM=IDLE.
  - An auto_start flag is set, so the first sequence runs without software action.
- Edge numbering: edge 1 is the first rising edge with rst_n high.
- FSM states: IDLE, PRE, ASSERT, RELEASE, DONE.
- IDLE:
  - If auto_start is set (edge 1) or start=1: capture domain_mask into mask_q, clear auto_start, go to PRE, busy=1 from that edge.
  - If the captured mask is 0: go directly to DONE; no domain asserts.
- PRE:
  - Counter runs PRE_CYCLES cycles; dom_reset stays 0.
  - dom_reset[mask_q] rises at edge s+PRE_CYCLES, where s is the start edge.
  - Defaults with auto-start: rise at edge 4.
- ASSERT:
  - Masked bits are held high for ASSERT_CYCLES cycles.
  - Unmasked bits stay 0 throughout the sequence.
- RELEASE:
  - Domain i falls at edge r+ASSERT_CYCLES+i*STAGGER_CYCLES, where r is the rise edge. Stagger slot is by index, independent of mask.
  - When the highest set bit h of mask_q falls, go to DONE on the same edge.
  - STAGGER_CYCLES=0 means all domains fall together.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - A start sampled in the DONE cycle is dropped (start_dropped set).
  - A start on the edge after DONE, in IDLE, is accepted.
- start while busy: ignored; start_dropped set sticky and cleared only by rst_n.
- domain_mask changes mid-sequence have no effect.
- rst_n assertion mid-sequence:
  - All outputs clear immediately (async) and auto_start is re-armed.
  - After release the full sequence reruns from edge 1.
- Heartbeat:
  - hb_cnt counts 0..HB_PERIOD-1 and wraps; it runs in every FSM state.
  - heartbeat=1 in the cycle where hb_cnt==HB_PERIOD-1, i.e. registered high after edges HB_PERIOD, 2*HB_PERIOD, ...
  - heartbeat_count increments on each pulse and saturates at all-ones (no wrap).
- Output registering:
  - All outputs are registered and glitch-free.
  - dom_reset bits each come directly from a flop.
- Width rules:
  - Phase counter width is clog2(max(PRE_CYCLES, ASSERT_CYCLES+(NUM_DOMAINS-1)*STAGGER_CYCLES)+1).
  - hb_cnt width is clog2(HB_PERIOD).

Test Plan:
- Defaults, rst_n released, no start -> dom_reset=4'hF from edge 4; bit0 falls at edge 7, bit1 at 9, bit2 at 11, bit3 at 13; done=1 and busy=0 after edge 13; start_dropped=0.
- After the auto sequence, domain_mask=4'b0101 and start at edge 20 -> bits 0 and 2 rise at edge 23; bit0 falls at 26, bit2 at 30; done after edge 30; bits 1 and 3 stay 0.
- start held high through a busy sequence -> start_dropped=1 and stays 1; exactly one done pulse; a start after done is accepted; domain_mask changes during the sequence do not alter dom_reset.
- domain_mask=0 with start -> busy for one cycle, done pulse, dom_reset never asserts.
- rst_n pulsed low at edge 8 mid-RELEASE -> dom_reset=0 immediately, asynchronously; after release the sequence repeats with rise at the new edge 4.
- HB_PERIOD=4, HB_WIDTH=2, run 20 cycles -> heartbeat pulses at cycles 4, 8, 12, 16, 20; heartbeat_count reads 1, 2, 3, 3, 3 (saturated).
